// File: rtl/g_output_splitter_pkg.sv
// ---------------------------------------------------------------------------
// g_output_splitter_pkg
// Shared Kyber constants for the G-hash output splitter: digest/half/word
// geometry, the splitter FSM state encoding, and a helper that turns a word
// index into a bit offset inside one 256-bit half.
// ---------------------------------------------------------------------------
package g_output_splitter_pkg;

  localparam int D_SIZE  = 512;              // SHA3-512 digest width
  localparam int HALF    = 256;              // width of rho and of sigma
  localparam int WORD_W  = 32;               // streamed word width
  localparam int N_WORDS = HALF / WORD_W;    // words per half (8)

  localparam int IDX_W  = $clog2(N_WORDS);   // word counter width (3)
  localparam int BASE_W = $clog2(HALF);      // bit offset width inside a half (8)

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_STREAM = 2'b01,
    ST_FIN    = 2'b10
  } state_t;

  // First bit of word k inside a half. WORD_W is a power of two, so the
  // offset is the word index with log2(WORD_W) zeros appended.
  function automatic logic [BASE_W-1:0] word_base(input logic [IDX_W-1:0] k);
    return {k, {(BASE_W - IDX_W){1'b0}}};
  endfunction

endpackage

// File: rtl/g_output_splitter_if.sv
// ---------------------------------------------------------------------------
// g_output_splitter_if
// Bundles the digest capture handshake and the two word-stream channels of
// the G-hash output splitter.
//   z_in/z_valid/z_ready         : digest capture from the SHA3-512 stage
//   rho_data/valid/ready/last    : rho stream to the matrix sampler
//   sigma_data/valid/ready/last  : sigma stream to the CBD noise sampler
//   done                         : one-cycle pulse, both halves transferred
//   drop_err                     : sticky, a digest strobe arrived while busy
// master = the surrounding datapath, slave = the splitter.
// ---------------------------------------------------------------------------
interface g_output_splitter_if;
  import g_output_splitter_pkg::*;

  logic [0:D_SIZE-1] z_in;          // bit 0 is the first digest bit
  logic              z_valid;
  logic              z_ready;

  logic [WORD_W-1:0] rho_data;
  logic              rho_valid;
  logic              rho_ready;
  logic              rho_last;

  logic [WORD_W-1:0] sigma_data;
  logic              sigma_valid;
  logic              sigma_ready;
  logic              sigma_last;

  logic              done;
  logic              drop_err;

  modport master (
    output z_in, z_valid, rho_ready, sigma_ready,
    input  z_ready, rho_data, rho_valid, rho_last,
           sigma_data, sigma_valid, sigma_last, done, drop_err
  );

  modport slave (
    input  z_in, z_valid, rho_ready, sigma_ready,
    output z_ready, rho_data, rho_valid, rho_last,
           sigma_data, sigma_valid, sigma_last, done, drop_err
  );

endinterface

// File: rtl/g_output_splitter_channel.sv
// ---------------------------------------------------------------------------
// g_word_channel
// Streams one 256-bit half as eight 32-bit words over a valid/ready channel.
// Word k is half[32k : 32k+31], with half[32k] on data[31].
//   clk, rst   : clock, asynchronous active-high reset
//   start      : capture strobe from the top; rewinds the channel
//   active     : top FSM is streaming
//   half       : the buffered half (rho or sigma)
//   ready      : consumer accepts the current word
//   data       : current word, indexed combinationally by the counter
//   valid      : word available (active and not yet finished)
//   last       : current word is the final one
//   chan_done  : all eight words transferred since the last start
// ---------------------------------------------------------------------------
module g_word_channel
  import g_output_splitter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              active,
  input  logic [0:HALF-1]   half,
  input  logic              ready,
  output logic [WORD_W-1:0] data,
  output logic              valid,
  output logic              last,
  output logic              chan_done
);

  logic [IDX_W-1:0] cnt_q;
  logic             done_q;
  logic             xfer;

  assign valid     = active && !done_q;
  assign last      = valid && (cnt_q == LAST_IDX);
  assign xfer      = valid && ready;
  assign chan_done = done_q;

  // Ascending source slice onto a descending word: the lowest-numbered
  // buffer bit lands on the MSB.
  assign data = half[word_base(cnt_q) +: WORD_W];

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (start) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (xfer) begin
      // The done flag, not counter wrap, ends the stream; the counter
      // parks on the last index until the next start.
      if (cnt_q == LAST_IDX) begin
        done_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/g_output_splitter.sv
// ---------------------------------------------------------------------------
// g_output_splitter
// Captures the 512-bit G-hash digest Z and streams rho = Z[0:255] and
// sigma = Z[256:511] as eight 32-bit words each on two independent
// valid/ready channels.
//   clk  : clock
//   rst  : asynchronous, active-high reset
//   bus  : g_output_splitter_if.slave (capture handshake, rho and sigma
//          streams, done pulse, sticky drop_err)
// FSM: IDLE (ready to capture) -> STREAM (channels run) -> FIN (done pulse).
// ---------------------------------------------------------------------------
module g_output_splitter
  import g_output_splitter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  g_output_splitter_if.slave bus
);

  state_t            state_q;
  state_t            state_d;
  logic [0:D_SIZE-1] buf_q;
  logic              drop_q;

  logic              capture;
  logic              streaming;
  logic              rho_done;
  logic              sigma_done;
  logic              rho_fin;
  logic              sigma_fin;

  assign capture   = (state_q == ST_IDLE) && bus.z_valid;
  assign streaming = (state_q == ST_STREAM);

  // A channel counts as finished if its flag is already set or its last
  // word is being accepted on this edge; this lets FIN follow the final
  // transfer directly instead of one cycle later.
  assign rho_fin   = rho_done   || (bus.rho_last   && bus.rho_ready);
  assign sigma_fin = sigma_done || (bus.sigma_last && bus.sigma_ready);

  // NOTE: the capture buffer is reset as well, so the data outputs read
  // zero out of reset rather than stale or unknown contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        buf_q <= bus.z_in;
      end
      // Any strobe outside IDLE (including the FIN cycle) is lost.
      if (bus.z_valid && (state_q != ST_IDLE)) begin
        drop_q <= 1'b1;
      end
    end
  end

  // NOTE: next state gets its default before the case so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.z_valid) state_d = ST_STREAM;
      ST_STREAM: if (rho_fin && sigma_fin) state_d = ST_FIN;
      ST_FIN:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  g_word_channel u_rho (
    .clk       (clk),
    .rst       (rst),
    .start     (capture),
    .active    (streaming),
    .half      (buf_q[0 +: HALF]),
    .ready     (bus.rho_ready),
    .data      (bus.rho_data),
    .valid     (bus.rho_valid),
    .last      (bus.rho_last),
    .chan_done (rho_done)
  );

  g_word_channel u_sigma (
    .clk       (clk),
    .rst       (rst),
    .start     (capture),
    .active    (streaming),
    .half      (buf_q[HALF +: HALF]),
    .ready     (bus.sigma_ready),
    .data      (bus.sigma_data),
    .valid     (bus.sigma_valid),
    .last      (bus.sigma_last),
    .chan_done (sigma_done)
  );

  assign bus.z_ready  = (state_q == ST_IDLE);
  assign bus.done     = (state_q == ST_FIN);
  assign bus.drop_err = drop_q;

endmodule

// File: tb/tb_g_output_splitter.sv
// ---------------------------------------------------------------------------
// tb_g_output_splitter
// Self-checking bench for g_output_splitter. The reference model holds the
// expected rho and sigma words of the current digest in two queues, built
// bit by bit from the digest; a word leaves its queue when the bench offers
// ready while the model says a word is pending. done is expected in the
// first cycle both queues are empty, and drop_err is a sticky model bit set
// whenever the bench strobes z_valid outside the idle window.
// ---------------------------------------------------------------------------
module tb_g_output_splitter;
  import g_output_splitter_pkg::*;

  logic clk;
  logic rst;

  g_output_splitter_if bus ();

  g_output_splitter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit drop_exp = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Word k of half h: bits 256h+32k .. +31, first bit is the MSB.
  function automatic logic [31:0] ref_word(input logic [0:D_SIZE-1] z, input int h, input int k);
    logic [31:0] w;
    for (int b = 0; b < 32; b++) w[31-b] = z[h*256 + 32*k + b];
    return w;
  endfunction

  // Digest whose rho word k is k and sigma word k is 0x10000000+k.
  function automatic logic [0:D_SIZE-1] make_pat();
    logic [0:D_SIZE-1] z;
    logic [31:0]       w;
    z = '0;
    for (int k = 0; k < 8; k++) begin
      w = k;
      for (int b = 0; b < 32; b++) z[32*k + b] = w[31-b];
      w = 32'h1000_0000 + k;
      for (int b = 0; b < 32; b++) z[256 + 32*k + b] = w[31-b];
    end
    return z;
  endfunction

  function automatic logic [0:D_SIZE-1] make_rand();
    logic [0:D_SIZE-1] z;
    logic [31:0]       w;
    for (int k = 0; k < 16; k++) begin
      w = $urandom;
      for (int b = 0; b < 32; b++) z[32*k + b] = w[b];
    end
    return z;
  endfunction

  // Idle cycles: nothing streams, readies toggle freely with no effect.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.z_valid     = 1'b0;
      bus.rho_ready   = 1'($urandom_range(0, 1));
      bus.sigma_ready = 1'($urandom_range(0, 1));
      check("idle_rho_valid",   32'(bus.rho_valid),   32'd0);
      check("idle_sigma_valid", 32'(bus.sigma_valid), 32'd0);
      check("idle_done",        32'(bus.done),        32'd0);
      check("idle_z_ready",     32'(bus.z_ready),     32'd1);
      check("idle_drop_err",    32'(bus.drop_err),    32'(drop_exp));
      step();
    end
  endtask

  // One capture plus its stream. mode: 0 readies high, 1 random readies,
  // 2 rho_ready low in cycles 2..4. inject_at: cycle index of a stray
  // z_valid (0 = none). abort_at: cycle index of a mid-stream reset
  // (0 = none). exp_done: required cycle index of done (0 = unchecked).
  task automatic run_stream(input logic [0:D_SIZE-1] z, input int mode,
                            input int inject_at, input int abort_at, input int exp_done);
    logic [31:0] rq[$];
    logic [31:0] sq[$];
    bit          done_seen;
    bit          both_empty;
    bit          rr, sr, rho_pop, sig_pop;
    int          idx;

    for (int k = 0; k < 8; k++) begin
      rq.push_back(ref_word(z, 0, k));
      sq.push_back(ref_word(z, 1, k));
    end

    check("cap_z_ready", 32'(bus.z_ready), 32'd1);
    bus.z_in    = z;
    bus.z_valid = 1'b1;
    step();
    bus.z_valid = 1'b0;
    bus.z_in    = '0;

    done_seen = 1'b0;
    idx       = 1;
    while (!done_seen && idx < 200) begin
      if (abort_at == idx) begin
        rst = 1'b1;
        #1;
        check("rst_rho_valid",   32'(bus.rho_valid),   32'd0);
        check("rst_sigma_valid", 32'(bus.sigma_valid), 32'd0);
        check("rst_rho_last",    32'(bus.rho_last),    32'd0);
        check("rst_z_ready",     32'(bus.z_ready),     32'd1);
        check("rst_done",        32'(bus.done),        32'd0);
        check("rst_rho_data",    bus.rho_data,         32'd0);
        check("rst_sigma_data",  bus.sigma_data,       32'd0);
        check("rst_drop_err",    32'(bus.drop_err),    32'd0);
        drop_exp = 1'b0;
        step();
        rst = 1'b0;
        return;
      end

      both_empty = (rq.size() == 0) && (sq.size() == 0);
      check("st_done",        32'(bus.done),        32'(both_empty));
      check("st_z_ready",     32'(bus.z_ready),     32'd0);
      check("st_drop_err",    32'(bus.drop_err),    32'(drop_exp));
      check("st_rho_valid",   32'(bus.rho_valid),   32'(rq.size() != 0));
      check("st_sigma_valid", 32'(bus.sigma_valid), 32'(sq.size() != 0));
      if (rq.size() != 0) begin
        check("rho_data", bus.rho_data,       rq[0]);
        check("rho_last", 32'(bus.rho_last), 32'(rq.size() == 1));
      end else begin
        check("rho_last_off", 32'(bus.rho_last), 32'd0);
      end
      if (sq.size() != 0) begin
        check("sigma_data", bus.sigma_data,       sq[0]);
        check("sigma_last", 32'(bus.sigma_last), 32'(sq.size() == 1));
      end else begin
        check("sigma_last_off", 32'(bus.sigma_last), 32'd0);
      end
      if (both_empty) begin
        done_seen = 1'b1;
        if (exp_done != 0) check("done_cycle", 32'(idx), 32'(exp_done));
      end

      case (mode)
        1:       begin rr = ($urandom_range(0, 3) != 0); sr = ($urandom_range(0, 3) != 0); end
        2:       begin rr = !(idx >= 2 && idx <= 4); sr = 1'b1; end
        default: begin rr = 1'b1; sr = 1'b1; end
      endcase
      bus.rho_ready   = rr;
      bus.sigma_ready = sr;
      if (inject_at == idx) begin
        bus.z_in    = ~z;
        bus.z_valid = 1'b1;
        drop_exp    = 1'b1;
      end
      rho_pop = rr && (rq.size() != 0);
      sig_pop = sr && (sq.size() != 0);

      step();
      bus.z_valid = 1'b0;
      if (rho_pop) void'(rq.pop_front());
      if (sig_pop) void'(sq.pop_front());
      idx++;
    end

    if (!done_seen) check("stream_timeout", 32'd0, 32'd1);
    check("end_z_ready",     32'(bus.z_ready),     32'd1);
    check("end_done",        32'(bus.done),        32'd0);
    check("end_rho_valid",   32'(bus.rho_valid),   32'd0);
    check("end_sigma_valid", 32'(bus.sigma_valid), 32'd0);
    check("end_drop_err",    32'(bus.drop_err),    32'(drop_exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:D_SIZE-1] pat;
    logic [0:D_SIZE-1] one_bit;

    rst             = 1'b1;
    bus.z_in        = '0;
    bus.z_valid     = 1'b0;
    bus.rho_ready   = 1'b0;
    bus.sigma_ready = 1'b0;
    #2;
    check("reset_z_ready",     32'(bus.z_ready),     32'd1);
    check("reset_rho_valid",   32'(bus.rho_valid),   32'd0);
    check("reset_sigma_valid", 32'(bus.sigma_valid), 32'd0);
    check("reset_rho_last",    32'(bus.rho_last),    32'd0);
    check("reset_sigma_last",  32'(bus.sigma_last),  32'd0);
    check("reset_done",        32'(bus.done),        32'd0);
    check("reset_drop_err",    32'(bus.drop_err),    32'd0);
    check("reset_rho_data",    bus.rho_data,         32'd0);
    check("reset_sigma_data",  bus.sigma_data,       32'd0);
    step();
    step();
    rst = 1'b0;
    idle(2);

    pat = make_pat();

    // Straight-through stream with both readies high.
    run_stream(pat, 0, 0, 0, 9);
    idle(2);

    // rho stalls on word 1 for three cycles; sigma runs ahead.
    run_stream(pat, 2, 0, 0, 12);
    idle(1);

    // Stray digest mid-stream: ignored, drop_err latches and stays.
    run_stream(pat, 0, 3, 0, 9);
    idle(3);

    // Reset mid-stream clears everything, then a fresh capture works.
    run_stream(pat, 0, 0, 4, 0);
    idle(3);
    run_stream(pat, 0, 0, 0, 9);
    idle(1);

    // Bit order: digest bit 0 alone lands on rho word 0 MSB.
    one_bit    = '0;
    one_bit[0] = 1'b1;
    run_stream(one_bit, 0, 0, 0, 9);

    // Back-to-back captures right after done; drop_err must stay clear.
    run_stream(make_rand(), 0, 0, 0, 9);
    run_stream(make_rand(), 0, 0, 0, 9);
    idle(1);

    // Strobe during the FIN cycle is dropped.
    run_stream(pat, 0, 9, 0, 9);
    idle(2);

    // Random digests with random back-pressure and random gaps.
    for (int i = 0; i < 20; i++) begin
      run_stream(make_rand(), 1, 0, 0, 0);
      idle($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/g_output_splitter.md
Name: g_output_splitter

Overview:
- Downstream consumer of the G hash (SHA3-512) output in the Kyber datapath.
- Captures the 512-bit digest Z when the controller strobes it.
- Splits Z into rho (Z[0:255]) and sigma (Z[256:511]).
- Streams each half as eight 32-bit words on two independent valid/ready channels: rho feeds the matrix sampler, sigma feeds the CBD noise sampler.

Parameters:
- D_SIZE, 512, digest width in bits.
- HALF, 256, width of rho and of sigma.
- WORD_W, 32, output word width.
- N_WORDS, 8, words per half (HALF/WORD_W).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- z_in  input  [0:511]  digest from the SHA3-512 stage; bit 0 is the first digest bit.
- z_valid  input  1  one-cycle strobe: z_in holds the final digest.
- z_ready  output  1  high when the block is idle and can capture.
- rho_data  output  [31:0]  current rho word.
- rho_valid  output  1  rho_data is valid.
- rho_ready  input  1  rho consumer accepts.
- rho_last  output  1  current rho word is word 7.
- sigma_data  output  [31:0]  current sigma word.
- sigma_valid  output  1  sigma_data is valid.
- sigma_ready  input  1  sigma consumer accepts.
- sigma_last  output  1  current sigma word is word 7.
- done  output  1  one-cycle pulse when both halves are fully transferred.
- drop_err  output  1  sticky flag: a z_valid strobe arrived while busy.

Behaviour:
- Reset values:
  - State IDLE, buffer zero, both word counters 0.
  - z_ready=1. rho_valid=sigma_valid=0. rho_last=sigma_last=0. done=0. drop_err=0. Data outputs 0.
- FSM states: IDLE, STREAM, FIN.
  - IDLE: z_ready=1. On z_valid, capture z_in into a 512-bit register, clear both counters and both channel-done flags, go to STREAM.
  - STREAM: z_ready=0. Each channel runs independently. Go to FIN when both channel-done flags are set.
  - FIN: done=1 for exactly one cycle, z_ready=0, then go to IDLE.
- Word mapping:
  - Rho word k (k=0..7) is buf[32k : 32k+31]; buf[32k] maps to rho_data[31] (MSB).
  - Sigma word k is buf[256+32k : 256+32k+31], with the same bit mapping.
  - Data is driven combinationally from the buffer, indexed by the counter.
- Per-channel handshake:
  - valid=1 while in STREAM and that channel's done flag is clear.
  - A transfer occurs on a rising edge with valid&&ready.
  - On transfer with counter<7: counter increments.
  - On transfer with counter==7: the done flag sets and valid drops the next cycle.
  - last = valid && counter==7.
  - Data stays stable while valid&&!ready.
  - valid never drops without a transfer.
- Latency:
  - Capture on edge N: both valids high from cycle N+1 with word 0.
  - With both readies held high, word k transfers at edge N+1+k and the last word at edge N+8.
  - State is FIN in cycle N+9 (done=1); IDLE and z_ready=1 from cycle N+10.
- Skew: channels may finish at different cycles. A finished channel holds valid=0 until the next capture.
- z_valid while not IDLE: ignored (buffer unchanged), drop_err set and held until rst.
- z_valid in the same cycle as the FIN pulse: dropped, drop_err set.
- Ready asserted while valid=0: no effect.
- rst mid-stream: all state returns to reset values immediately (asynchronous). A partial transfer is abandoned; no done pulse.
- Counters are 3 bits and never wrap inside a stream; the done flag gates further increments.

Decomposition:
- Shared Kyber package holds:
  - constants D_SIZE=512, HALF=256, WORD_W=32, N_WORDS=8;
  - the FSM state encoding (IDLE=2'b00, STREAM=2'b01, FIN=2'b10).
- One natural sub-module: g_word_channel, instantiated twice (rho, sigma). It takes a 256-bit half, a start pulse, and ready, and returns data/valid/last/chan_done.
- The top holds the capture buffer, the FSM, done and drop_err.

Test Plan:
- Reset, then capture z_in with word pattern rho word k = 32'h0000_0000+k and sigma word k = 32'h1000_0000+k, both readies high -> rho_data 0..7 and sigma_data 32'h10000000..32'h10000007 on cycles N+1..N+8; last only on word 7; done at N+9; z_ready=1 at N+10.
- Same digest, rho_ready low for cycles N+2..N+4, sigma_ready always high -> rho word 1 held stable for 3 cycles; sigma finishes at N+8, rho at N+11; single done pulse at N+12.
- Second z_valid (different value) at N+3 during STREAM -> outputs still match the first digest; drop_err=1 and remains 1 after done.
- Assert rst at N+4 mid-stream -> all valids 0, counters 0, z_ready=1 immediately; no done pulse; a fresh capture afterwards streams from word 0 correctly.
- Bit-order check: z_in bit 0 = 1, all else 0 -> rho word 0 = 32'h8000_0000; all other words 0.
- Back-to-back captures: z_valid in cycle N+10 right after the first done -> the second stream starts at N+11; drop_err stays 0.
